stage_rf_read: RTL and testbench
================================

// Module: stage_rf_read
// PURPOSE
//  Register-file read side of the pipeline: the consumer of the write-back stage's
//  (rdst, reg_write, mux data) triple. Holds the NREG x WIDTH architectural register
//  array, takes the WB write port, and presents two registered source operands to
//  the decode/execute boundary. WB write-first bypass and stall-time operand refresh
//  remove the need for a delayed (virtual) WB copy on the read side.
// PARAMETERS
//  WIDTH    32  data width of registers and operands
//  NREG     32  number of architectural registers
//  AW       5   register index width, clog2(NREG)
//  R0_ZERO  1   1: r0 reads 0 and ignores writes; 0: r0 is an ordinary register
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous reset, active-low
//  i_rf_we      in   1      write enable from WB (o_wb_reg_write_rf)
//  i_rf_wdst    in   AW     write register index (o_wb_rdst)
//  i_rf_wdata   in   WIDTH  write data (o_wb_mux)
//  i_rf_rs1     in   AW     source-1 index from decode
//  i_rf_rs2     in   AW     source-2 index from decode
//  i_rf_stall   in   1      hold captured operands (pipeline stall)
//  i_rf_flush   in   1      bubble: zero captured operands
//  o_rf_op1     out  WIDTH  registered source-1 operand
//  o_rf_op2     out  WIDTH  registered source-2 operand
//  o_rf_rs1     out  AW     index captured with o_rf_op1
//  o_rf_rs2     out  AW     index captured with o_rf_op2
//  o_rf_byp1    out  1      o_rf_op1 was last loaded from the WB bypass
//  o_rf_byp2    out  1      o_rf_op2 was last loaded from the WB bypass
// BEHAVIOUR
//  - Reset (rst=0, async): all array entries, o_rf_op*, o_rf_rs*, o_rf_byp* = 0.
//  - Write: on posedge, if i_rf_we and !(R0_ZERO && i_rf_wdst==0), array[wdst]<=wdata.
//    Writes are never blocked by stall or flush.
//  - Read value rdN = (R0_ZERO && idx==0) ? 0 :
//    (i_rf_we && i_rf_wdst==idx) ? i_rf_wdata : array[idx]  (write-first bypass).
//  - Capture, per posedge, priority high->low:
//    1) i_rf_flush: op*,rs*,byp* <= 0 (flush beats stall).
//    2) !i_rf_stall: opN <= rdN(i_rf_rsN); rsN <= i_rf_rsN; bypN <= bypass hit.
//    3) i_rf_stall: rsN held; if i_rf_we && i_rf_wdst==o_rf_rsN and not masked r0,
//       opN <= i_rf_wdata, bypN <= 1 (refresh); else opN, bypN held.
//  - Latency: 1 cycle index->operand; a WB write at edge k is visible in the
//    operand captured at edge k (bypass) and from the array thereafter.
//  - rs1==rs2: both ports return identical data and bypass flags.
//  - Index >= NREG (when NREG < 2**AW): read returns 0, write is dropped.
//  - No X on outputs after reset; array is not initialised other than by reset.
// TESTING
//  1 reset: drop rst mid-run with op1=0x1234 -> op1/op2/rs/byp = 0 immediately
//    (async), array reads 0.
//  2 write then read: we=1,wdst=5,wdata=0xDEADBEEF @k; rs1=5 @k+1
//    -> op1=0xDEADBEEF @k+2, byp1=0.
//  3 bypass: we=1,wdst=7,wdata=0xA5A5A5A5 with rs1=rs2=7 same cycle
//    -> op1=op2=0xA5A5A5A5, byp1=byp2=1 next cycle.
//  4 r0: we=1,wdst=0,wdata=0xFFFFFFFF; rs1=0 -> op1=0, byp1=0 (R0_ZERO=1);
//    with R0_ZERO=0 -> op1=0xFFFFFFFF.
//  5 stall refresh: capture rs2=9 (0x11), hold stall=1, write r9=0x22
//    -> op2=0x22, byp2=1 while still stalled; rs change during stall ignored.
//  6 flush vs stall: stall=1, flush=1 same cycle, op1=0x33 -> op1=0, rs1=0, byp1=0.

Source files
------------

// File: rtl/stage_rf_read.sv
// Register-file read stage: NREG x WIDTH architectural register array with the
// WB write port, write-first bypass, and two registered source operands that
// are held on stall (with WB refresh) and zeroed on flush.
module stage_rf_read #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NREG    = 32,
    parameter int unsigned AW      = 5,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rf_we,
    input  logic [AW-1:0]    i_rf_wdst,
    input  logic [WIDTH-1:0] i_rf_wdata,
    input  logic [AW-1:0]    i_rf_rs1,
    input  logic [AW-1:0]    i_rf_rs2,
    input  logic             i_rf_stall,
    input  logic             i_rf_flush,
    output logic [WIDTH-1:0] o_rf_op1,
    output logic [WIDTH-1:0] o_rf_op2,
    output logic [AW-1:0]    o_rf_rs1,
    output logic [AW-1:0]    o_rf_rs2,
    output logic             o_rf_byp1,
    output logic             o_rf_byp2
);

    logic [WIDTH-1:0] regs [NREG];

    logic             wr_ok;
    logic [WIDTH-1:0] rd1, rd2;
    logic             hit1, hit2;
    logic             rfr1, rfr2;

    // True when an index addresses an implemented register
    function automatic logic in_range(input logic [AW-1:0] idx);
        return (int'(idx) < int'(NREG));
    endfunction

    // True when an index is the hard-wired zero register
    function automatic logic is_r0(input logic [AW-1:0] idx);
        return R0_ZERO && (idx == '0);
    endfunction

    // Effective write: enabled, in range, and not the masked r0
    always_comb begin
        wr_ok = i_rf_we && in_range(i_rf_wdst) && !is_r0(i_rf_wdst);
    end

    // Source-1 read with write-first bypass from the WB port
    always_comb begin
        rd1  = '0;
        hit1 = 1'b0;
        if (!is_r0(i_rf_rs1) && in_range(i_rf_rs1)) begin
            if (wr_ok && (i_rf_wdst == i_rf_rs1)) begin
                rd1  = i_rf_wdata;
                hit1 = 1'b1;
            end else begin
                rd1 = regs[i_rf_rs1];
            end
        end
    end

    // Source-2 read with write-first bypass from the WB port
    always_comb begin
        rd2  = '0;
        hit2 = 1'b0;
        if (!is_r0(i_rf_rs2) && in_range(i_rf_rs2)) begin
            if (wr_ok && (i_rf_wdst == i_rf_rs2)) begin
                rd2  = i_rf_wdata;
                hit2 = 1'b1;
            end else begin
                rd2 = regs[i_rf_rs2];
            end
        end
    end

    // Stall-time refresh: a WB write to a held index overwrites the held operand
    always_comb begin
        rfr1 = wr_ok && (i_rf_wdst == o_rf_rs1);
        rfr2 = wr_ok && (i_rf_wdst == o_rf_rs2);
    end

    // Architectural array: WB writes are never blocked by stall or flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[i_rf_wdst] <= i_rf_wdata;
        end
    end

    // Operand capture: flush beats stall, stall holds with WB refresh
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_rf_op1  <= '0;
            o_rf_op2  <= '0;
            o_rf_rs1  <= '0;
            o_rf_rs2  <= '0;
            o_rf_byp1 <= 1'b0;
            o_rf_byp2 <= 1'b0;
        end else if (i_rf_flush) begin
            o_rf_op1  <= '0;
            o_rf_op2  <= '0;
            o_rf_rs1  <= '0;
            o_rf_rs2  <= '0;
            o_rf_byp1 <= 1'b0;
            o_rf_byp2 <= 1'b0;
        end else if (!i_rf_stall) begin
            o_rf_op1  <= rd1;
            o_rf_op2  <= rd2;
            o_rf_rs1  <= i_rf_rs1;
            o_rf_rs2  <= i_rf_rs2;
            o_rf_byp1 <= hit1;
            o_rf_byp2 <= hit2;
        end else begin
            if (rfr1) begin
                o_rf_op1  <= i_rf_wdata;
                o_rf_byp1 <= 1'b1;
            end
            if (rfr2) begin
                o_rf_op2  <= i_rf_wdata;
                o_rf_byp2 <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stage_rf_read.sv
// Testbench for stage_rf_read: directed and random steps, a reference model
// pushes expected operand state per cycle, popped and checked after each edge.
module tb_stage_rf_read;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  wdst;
    logic [31:0] wdata;
    logic [4:0]  rs1, rs2;
    logic        stall, flush;

    logic [31:0] op1, op2;
    logic [4:0]  ors1, ors2;
    logic        byp1, byp2;

    logic [31:0] z_op1, z_op2;
    logic [4:0]  z_rs1, z_rs2;
    logic        z_byp1, z_byp2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        b1;
        logic        b2;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_rf [32];
    exp_t        m_st;

    stage_rf_read #(.WIDTH(32), .NREG(32), .AW(5), .R0_ZERO(1'b1)) u_dut (
        .clk(clk), .rst(rst), .i_rf_we(we), .i_rf_wdst(wdst), .i_rf_wdata(wdata),
        .i_rf_rs1(rs1), .i_rf_rs2(rs2), .i_rf_stall(stall), .i_rf_flush(flush),
        .o_rf_op1(op1), .o_rf_op2(op2), .o_rf_rs1(ors1), .o_rf_rs2(ors2),
        .o_rf_byp1(byp1), .o_rf_byp2(byp2)
    );

    // Second instance with r0 as an ordinary register
    stage_rf_read #(.WIDTH(32), .NREG(32), .AW(5), .R0_ZERO(1'b0)) u_dut_r0 (
        .clk(clk), .rst(rst), .i_rf_we(we), .i_rf_wdst(wdst), .i_rf_wdata(wdata),
        .i_rf_rs1(rs1), .i_rf_rs2(rs2), .i_rf_stall(stall), .i_rf_flush(flush),
        .o_rf_op1(z_op1), .o_rf_op2(z_op2), .o_rf_rs1(z_rs1), .o_rf_rs2(z_rs2),
        .o_rf_byp1(z_byp1), .o_rf_byp2(z_byp2)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_st = '0;
    endtask

    // Reference read of the R0_ZERO=1 configuration
    task automatic m_read(input logic [4:0] idx, output logic [31:0] v, output logic h);
        logic wok;
        wok = we && (wdst != 5'd0);
        v = '0;
        h = 1'b0;
        if (idx != 5'd0) begin
            if (wok && wdst == idx) begin
                v = wdata;
                h = 1'b1;
            end else begin
                v = m_rf[idx];
            end
        end
    endtask

    // Advance the model by one edge using the current inputs and push the result
    task automatic model_push();
        logic        wok;
        logic [31:0] v1, v2;
        logic        h1, h2;
        wok = we && (wdst != 5'd0);
        m_read(rs1, v1, h1);
        m_read(rs2, v2, h2);
        if (flush) begin
            m_st = '0;
        end else if (!stall) begin
            m_st.op1 = v1; m_st.op2 = v2;
            m_st.rs1 = rs1; m_st.rs2 = rs2;
            m_st.b1 = h1; m_st.b2 = h2;
        end else begin
            if (wok && wdst == m_st.rs1) begin
                m_st.op1 = wdata; m_st.b1 = 1'b1;
            end
            if (wok && wdst == m_st.rs2) begin
                m_st.op2 = wdata; m_st.b2 = 1'b1;
            end
        end
        if (wok) m_rf[wdst] = wdata;
        sb_q.push_back(m_st);
    endtask

    task automatic cycle();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("sb_op1", op1, e.op1);
            chk("sb_op2", op2, e.op2);
            chk("sb_rs", {22'd0, ors1, ors2}, {22'd0, e.rs1, e.rs2});
            chk("sb_byp", {30'd0, byp1, byp2}, {30'd0, e.b1, e.b2});
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] d, input logic [31:0] v,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic st, input logic fl);
        we = w; wdst = d; wdata = v; rs1 = s1; rs2 = s2; stall = st; flush = fl;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        model_reset();
        #2;
        chk("rst_op1", op1, 32'd0);
        chk("rst_op2", op2, 32'd0);
        chk("rst_byp", {30'd0, byp1, byp2}, 32'd0);
        #10 rst = 1'b1;

        // Write r5 then read it through the array
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 1'b0); cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 1'b0);        cycle();
        chk("wr_rd_op1", op1, 32'hDEADBEEF);
        chk("wr_rd_byp1", {31'd0, byp1}, 32'd0);

        // Same-cycle bypass to both ports
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0, 1'b0); cycle();
        chk("byp_op1", op1, 32'hA5A5A5A5);
        chk("byp_op2", op2, 32'hA5A5A5A5);
        chk("byp_flags", {30'd0, byp1, byp2}, 32'd3);

        // r0 masking vs ordinary r0
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 1'b0, 1'b0); cycle();
        chk("r0_byp_op1", op1, 32'd0);
        chk("r0_byp_b1", {31'd0, byp1}, 32'd0);
        chk("r0n_byp_op1", z_op1, 32'hFFFFFFFF);
        chk("r0n_byp_b1", {31'd0, z_byp1}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd5, 1'b0, 1'b0);        cycle();
        chk("r0_op1", op1, 32'd0);
        chk("r0n_op1", z_op1, 32'hFFFFFFFF);
        chk("r0n_b1", {31'd0, z_byp1}, 32'd0);

        // Stall refresh of a held operand; index change during stall ignored
        drive(1'b1, 5'd9, 32'h11, 5'd0, 5'd3, 1'b0, 1'b0);       cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd9, 1'b0, 1'b0);        cycle();
        chk("stl_cap_op2", op2, 32'h11);
        drive(1'b1, 5'd9, 32'h22, 5'd0, 5'd4, 1'b1, 1'b0);       cycle();
        chk("stl_rfr_op2", op2, 32'h22);
        chk("stl_rfr_b2", {31'd0, byp2}, 32'd1);
        chk("stl_rs2", {27'd0, ors2}, 32'd9);
        drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd4, 1'b1, 1'b0);        cycle();
        chk("stl_hold_op2", op2, 32'h22);
        chk("stl_hold_b2", {31'd0, byp2}, 32'd1);

        // Flush beats stall; writes still land during flush
        drive(1'b1, 5'd10, 32'h33, 5'd0, 5'd0, 1'b0, 1'b0);      cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd0, 1'b0, 1'b0);       cycle();
        chk("fl_pre_op1", op1, 32'h33);
        drive(1'b1, 5'd11, 32'h44, 5'd10, 5'd0, 1'b1, 1'b1);     cycle();
        chk("fl_op1", op1, 32'd0);
        chk("fl_rs1", {27'd0, ors1}, 32'd0);
        chk("fl_b1", {31'd0, byp1}, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 5'd11, 5'd10, 1'b0, 1'b0);      cycle();
        chk("fl_wr_op1", op1, 32'h44);
        chk("fl_wr_op2", op2, 32'h33);

        // Random traffic checked against the model
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom(),
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            cycle();
        end

        // Asynchronous reset in mid-run with a live operand
        drive(1'b1, 5'd12, 32'h1234, 5'd0, 5'd0, 1'b0, 1'b0);    cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd12, 5'd12, 1'b0, 1'b0);      cycle();
        chk("arst_pre_op1", op1, 32'h1234);
        #2 rst = 1'b0;
        #1;
        chk("arst_op1", op1, 32'd0);
        chk("arst_op2", op2, 32'd0);
        chk("arst_rs", {22'd0, ors1, ors2}, 32'd0);
        chk("arst_byp", {30'd0, byp1, byp2}, 32'd0);
        model_reset();
        #10 rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd12, 1'b0, 1'b0);       cycle();
        chk("arst_arr_op1", op1, 32'd0);
        chk("arst_arr_op2", op2, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
